// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode values,
// sequencer step encodings and the opcode field position inside IR.
package cpu_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU2,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } op_class_e;

    // The execute sequence length and strobe pattern depend only on the class.
    function automatic op_class_e classify(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return CLS_ALU2;
            OP_MUL, OP_DIV:                  return CLS_MULDIV;
            OP_NEG, OP_NOT:                  return CLS_UNARY;
            OP_NOP:                          return CLS_NOP;
            OP_HALT:                         return CLS_HALT;
            default:                         return CLS_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/step_timer.sv
// Counts T1 cycles spent waiting on memory and flags the cycle in which
// the wait budget runs out. A budget of zero never times out.
module step_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_t1_i,
    input  logic mem_ready_i,
    output logic timeout_o
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Held at zero outside T1 so every fresh T1 visit starts from a clean count.
    always_comb begin
        wait_cnt_d = '0;
        if (in_t1_i) begin
            wait_cnt_d = wait_cnt_q;
            if (!mem_ready_i && (wait_cnt_q != CNT_MAX)) begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    // A ready in the final cycle wins over the timeout.
    assign timeout_o = (MAX_WAIT > 0) && in_t1_i && !mem_ready_i && (wait_cnt_q == CNT_LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit: steps T0..T6 and decodes the
// DataPath register-transfer strobes from the current step and latched opcode.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int OP_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] ir,
    output logic              PCout,
    output logic              Zlowout,
    output logic              Zhighout,
    output logic              MDRout,
    output logic              PCin,
    output logic              MARin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              Zin,
    output logic              LOin,
    output logic              HIin,
    output logic              IncPC,
    output logic              Read,
    output logic [OP_W-1:0]   Operator,
    output logic              Gra,
    output logic              Grb,
    output logic              Grc,
    output logic              Rin,
    output logic              Rout,
    output logic              run,
    output logic              illegal_op,
    output logic              mem_timeout
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    op_class_e        op_cls;
    logic             timeout;
    logic             unused_ir;

    assign op_cls    = classify(opcode_q);
    assign unused_ir = ^ir[OPC_LSB-1:0];

    step_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_step_timer (
        .clk         (clk),
        .rst_n       (clear),
        .in_t1_i     (state_q == S_T1),
        .mem_ready_i (mem_ready),
        .timeout_o   (timeout)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q  <= S_RST;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // The opcode is captured only on the T2->T3 edge, so IR may change freely otherwise.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1: begin
                if (mem_ready)    state_d = S_T2;
                else if (timeout) state_d = S_HALT;
            end
            S_T2: begin
                state_d  = S_T3;
                opcode_d = ir[OPC_MSB:OPC_LSB];
            end
            S_T3: begin
                case (op_cls)
                    CLS_ALU2, CLS_MULDIV, CLS_UNARY: state_d = S_T4;
                    CLS_HALT:                        state_d = S_HALT;
                    default:                         state_d = S_T0;
                endcase
            end
            S_T4:    state_d = (op_cls == CLS_UNARY) ? S_T0 : S_T5;
            S_T5:    state_d = (op_cls == CLS_MULDIV) ? S_T6 : S_T0;
            S_T6:    state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; LOin = 1'b0; HIin = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Operator = '0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        run = (state_q != S_RST) && (state_q != S_HALT);
        illegal_op = 1'b0;
        mem_timeout = timeout;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (op_cls)
                    CLS_ALU2:    begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CLS_MULDIV:  begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CLS_UNARY:   begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; Operator = OP_W'(opcode_q); end
                    CLS_ILLEGAL: illegal_op = 1'b1;
                    default:     ;
                endcase
            end
            S_T4: begin
                case (op_cls)
                    CLS_ALU2:   begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; Operator = OP_W'(opcode_q); end
                    CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; Operator = OP_W'(opcode_q); end
                    CLS_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:    ;
                endcase
            end
            S_T5: begin
                case (op_cls)
                    CLS_ALU2:   begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
                    default:    ;
                endcase
            end
            S_T6: begin
                if (op_cls == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
